// File: rtl/pb_pkg.sv
// Shared constants and types for the push-button front end.
// Optional auto-repeat is enabled by defining PB_AUTOREPEAT_EN.
package pb_pkg;

  localparam int unsigned PB_NUM_BUTTONS      = 4;
  localparam int unsigned PB_TICK_PERIOD_1KHZ = 50000;
  localparam int unsigned PB_SHIFT_LEN        = 10;

  typedef logic [PB_NUM_BUTTONS-1:0] pb_vec_t;
  typedef logic [15:0]               pb_hold_cnt_t;

endpackage

// File: rtl/push_button_debouncer_if.sv
// Channel bundle: sampled button level and tick in, debounced level and pulses out.
// Master is the debounce channel, slave is the logic feeding/consuming it.
interface push_button_debouncer_if #(
  parameter int unsigned W = 1
) ();

  logic [W-1:0] pressed;
  logic         sample;
  logic [W-1:0] status;
  logic [W-1:0] press;
  logic [W-1:0] rel;

  modport master (
    input  pressed,
    input  sample,
    output status,
    output press,
    output rel
  );

  modport slave (
    output pressed,
    output sample,
    input  status,
    input  press,
    input  rel
  );

endinterface

// File: rtl/pb_debounce_channel.sv
// One debounce channel: sample shift register, debounced status, press/release pulses.
// With PB_AUTOREPEAT_EN defined, a hold counter re-issues press pulses while held.
module pb_debounce_channel
  import pb_pkg::*;
#(
  parameter int unsigned SHIFT_LEN    = PB_SHIFT_LEN,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic                    CLOCK_50_I,
  input  logic                    resetn,
  push_button_debouncer_if.master ch
);

  logic [SHIFT_LEN-1:0] shift_q, shift_d;
  logic                 status_q, status_d;
  logic                 status_dly_q, status_dly_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 press_edge;

`ifdef PB_AUTOREPEAT_EN
  localparam pb_hold_cnt_t HOLD_FIRE   = pb_hold_cnt_t'(REPEAT_DELAY - 1);
  localparam pb_hold_cnt_t HOLD_RELOAD = pb_hold_cnt_t'(REPEAT_DELAY - REPEAT_RATE);

  pb_hold_cnt_t hold_q, hold_d;
`endif

  always_comb begin
    shift_d = shift_q;
    if (ch.sample) begin
      shift_d = {shift_q[SHIFT_LEN-2:0], ch.pressed[0]};
    end
    // Any pressed sample in the window keeps status high: fast press, slow release.
    status_d     = |shift_q;
    status_dly_d = status_q;
    press_edge   = status_q & ~status_dly_q;
    press_d      = press_edge;
    release_d    = ~status_q & status_dly_q;
`ifdef PB_AUTOREPEAT_EN
    hold_d = hold_q;
    if (!status_q || press_edge) begin
      hold_d = '0;
    end else if (ch.sample) begin
      if (hold_q == HOLD_FIRE) begin
        press_d = 1'b1;
        hold_d  = HOLD_RELOAD;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      shift_q      <= '0;
      status_q     <= 1'b0;
      status_dly_q <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      status_q     <= status_d;
      status_dly_q <= status_dly_d;
      press_q      <= press_d;
      release_q    <= release_d;
    end
  end

`ifdef PB_AUTOREPEAT_EN
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign ch.status = status_q;
  assign ch.press  = press_q;
  assign ch.rel    = release_q;

endmodule

// File: rtl/push_button_debouncer.sv
// Push-button front end: 2-flop synchronisers, shared sample-tick divider, per-button debounce.
// Define PB_AUTOREPEAT_EN to enable hold-to-repeat press pulses.
module push_button_debouncer
  import pb_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS  = PB_NUM_BUTTONS,
  parameter int unsigned TICK_PERIOD  = PB_TICK_PERIOD_1KHZ,
  parameter int unsigned SHIFT_LEN    = PB_SHIFT_LEN,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic [NUM_BUTTONS-1:0] PUSH_BUTTON_N_I,
  output logic [NUM_BUTTONS-1:0] pb_status_o,
  output logic [NUM_BUTTONS-1:0] pb_press_o,
  output logic [NUM_BUTTONS-1:0] pb_release_o,
  output logic                   tick_o
);

  localparam int unsigned TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);

  logic [NUM_BUTTONS-1:0] sync_n_meta_q, sync_n_q;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic                   tick;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      sync_n_meta_q <= '1;
      sync_n_q      <= '1;
    end else begin
      sync_n_meta_q <= PUSH_BUTTON_N_I;
      sync_n_q      <= sync_n_meta_q;
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (tick) begin
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_o = tick;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    push_button_debouncer_if #(.W(1)) ch_if ();

    assign ch_if.pressed = ~sync_n_q[i];
    assign ch_if.sample  = tick;

    pb_debounce_channel #(
      .SHIFT_LEN    (SHIFT_LEN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_channel (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .ch         (ch_if.master)
    );

    assign pb_status_o[i]  = ch_if.status[0];
    assign pb_press_o[i]   = ch_if.press[0];
    assign pb_release_o[i] = ch_if.rel[0];
  end

endmodule

// File: tb/tb_push_button_debouncer.sv
// Directed bench for push_button_debouncer with TICK_PERIOD=4, SHIFT_LEN=3, REPEAT 5/2.
// Repeat expectations follow PB_AUTOREPEAT_EN.
module tb_push_button_debouncer;

`ifdef PB_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       resetn;
  logic [3:0] pins;
  logic       tick;

  int unsigned checks = 0;
  int unsigned errors = 0;

  push_button_debouncer_if #(.W(4)) pb_bus ();

  assign pb_bus.pressed = ~pins;
  assign pb_bus.sample  = tick;

  push_button_debouncer #(
    .NUM_BUTTONS  (4),
    .TICK_PERIOD  (4),
    .SHIFT_LEN    (3),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .CLOCK_50_I      (clk),
    .resetn          (resetn),
    .PUSH_BUTTON_N_I (pins),
    .pb_status_o     (pb_bus.status),
    .pb_press_o      (pb_bus.press),
    .pb_release_o    (pb_bus.rel),
    .tick_o          (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic align_tick();
    int unsigned n = 0;
    while (tick !== 1'b1 && n < 8) begin
      step(1);
      n++;
    end
    chk("align_tick", {31'd0, tick}, 32'd1);
  endtask

  initial begin
    logic exp_p;
    logic exp_r;

    // Reset with all pins pressed: outputs must stay 0
    resetn = 1'b0;
    pins   = 4'h0;
    step(3);
    chk("rst_status",  {28'd0, pb_bus.status}, 32'h0);
    chk("rst_press",   {28'd0, pb_bus.press},  32'h0);
    chk("rst_release", {28'd0, pb_bus.rel},    32'h0);
    chk("rst_tick",    {31'd0, tick},          32'h0);
    pins = 4'hF;
    step(1);
    resetn = 1'b1;

    // Tick cadence: first at counter 3, then every 4 cycles
    step(1); chk("tick_e1", {31'd0, tick}, 32'd0);
    step(1); chk("tick_e2", {31'd0, tick}, 32'd0);
    step(1); chk("tick_e3", {31'd0, tick}, 32'd1);
    step(1); chk("tick_e4", {31'd0, tick}, 32'd0);
    step(3); chk("tick_e7", {31'd0, tick}, 32'd1);

    // Clean press on button 0
    align_tick();
    pins[0] = 1'b0;
    step(5);
    chk("press0_e5_status", {28'd0, pb_bus.status}, 32'h0);
    chk("press0_e5_press",  {28'd0, pb_bus.press},  32'h0);
    step(1);
    chk("press0_e6_status", {28'd0, pb_bus.status}, 32'h1);
    chk("press0_e6_press",  {28'd0, pb_bus.press},  32'h0);
    step(1);
    chk("press0_e7_press",  {28'd0, pb_bus.press},  32'h1);
    step(1);
    chk("press0_e8_press",  {28'd0, pb_bus.press},  32'h0);
    chk("press0_e8_status", {28'd0, pb_bus.status}, 32'h1);
    chk("press0_e8_tick",   {31'd0, tick},          32'd1);

    // Bounce while held, then a clean 3-tick release
    pins[0] = 1'b1;
    for (int unsigned k = 1; k <= 21; k++) begin
      step(1);
      exp_p = AR && (k == 17);
      chk("bounce_status",  {28'd0, pb_bus.status}, 32'h1);
      chk("bounce_press",   {28'd0, pb_bus.press},  {31'd0, exp_p});
      chk("bounce_release", {28'd0, pb_bus.rel},    32'h0);
      if (k == 4) pins[0] = 1'b0;
      if (k == 8) pins[0] = 1'b1;
    end
    step(1);
    chk("rel0_e22_status",  {28'd0, pb_bus.status}, 32'h0);
    chk("rel0_e22_release", {28'd0, pb_bus.rel},    32'h0);
    step(1);
    chk("rel0_e23_release", {28'd0, pb_bus.rel},    32'h1);
    chk("rel0_e23_press",   {28'd0, pb_bus.press},  32'h0);
    step(1);
    chk("rel0_e24_release", {28'd0, pb_bus.rel},    32'h0);

    // Simultaneous press and release of buttons 1 and 3
    align_tick();
    pins = 4'b0101;
    step(5);
    chk("sim_e5_press",   {28'd0, pb_bus.press},  32'h0);
    step(1);
    chk("sim_e6_status",  {28'd0, pb_bus.status}, 32'hA);
    step(1);
    chk("sim_e7_press",   {28'd0, pb_bus.press},  32'hA);
    pins = 4'hF;
    step(1);
    chk("sim_e8_press",   {28'd0, pb_bus.press},  32'h0);
    step(14);
    chk("sim_e22_status", {28'd0, pb_bus.status}, 32'h0);
    chk("sim_e22_release",{28'd0, pb_bus.rel},    32'h0);
    step(1);
    chk("sim_e23_release",{28'd0, pb_bus.rel},    32'hA);
    step(1);
    chk("sim_e24_release",{28'd0, pb_bus.rel},    32'h0);

    // Reset while button 2 is held
    align_tick();
    pins[2] = 1'b0;
    step(7);
    chk("hold2_e7_press",  {28'd0, pb_bus.press},  32'h4);
    step(1);
    chk("hold2_e8_status", {28'd0, pb_bus.status}, 32'h4);
    resetn = 1'b0;
    #1;
    chk("midrst_status",  {28'd0, pb_bus.status}, 32'h0);
    chk("midrst_press",   {28'd0, pb_bus.press},  32'h0);
    chk("midrst_release", {28'd0, pb_bus.rel},    32'h0);
    step(2);
    chk("midrst_tick",    {31'd0, tick},          32'd0);
    resetn = 1'b1;
    step(3);
    chk("rerun_e3_tick",   {31'd0, tick},          32'd1);
    chk("rerun_e3_status", {28'd0, pb_bus.status}, 32'h0);
    step(2);
    chk("rerun_e5_status", {28'd0, pb_bus.status}, 32'h4);
    chk("rerun_e5_press",  {28'd0, pb_bus.press},  32'h0);
    step(1);
    chk("rerun_e6_press",  {28'd0, pb_bus.press},  32'h4);
    step(1);
    chk("rerun_e7_press",  {28'd0, pb_bus.press},  32'h0);
    pins = 4'hF;
    step(16);
    chk("rerun_e23_status",{28'd0, pb_bus.status}, 32'h0);

    // Long hold on button 0: edge pulse, plus repeats when enabled
    align_tick();
    pins[0] = 1'b0;
    for (int unsigned k = 1; k <= 60; k++) begin
      step(1);
      exp_p = (k == 7) || (AR && (k == 25 || k == 33 || k == 41 || k == 49));
      exp_r = (k == 55);
      chk("hold_press",   {28'd0, pb_bus.press}, {31'd0, exp_p});
      chk("hold_release", {28'd0, pb_bus.rel},   {31'd0, exp_r});
      if (k == 40) pins[0] = 1'b1;
    end
    chk("hold_end_status", {28'd0, pb_bus.status}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
